// File: rtl/stack_ctrl_pkg.sv
// Shared types for the REDUX-V stack controller: request opcodes, FSM states
// and the default data/address width.
package stack_ctrl_pkg;

  localparam int unsigned BITS_DEF = 8;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'd0,
    OP_POP   = 2'd1,
    OP_PEEK  = 2'd2,
    OP_CLEAR = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_PUSH_WR = 3'd1,
    ST_POP_DEC = 3'd2,
    ST_MEM_RD  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RESP    = 3'd5
  } state_e;

endpackage

// File: rtl/stack_mem.sv
// Behavioural single-port synchronous RAM backing the stack.
// Read data appears on rdata_o the cycle after re_i is sampled high.
module stack_mem #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic            re_i,
  input  logic [BITS-1:0] addr_i,
  input  logic [BITS-1:0] wdata_i,
  output logic [BITS-1:0] rdata_o
);

  logic [BITS-1:0] mem_q [2**BITS];

  // Single port: write or registered read at the addressed location.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/stack_ctrl.sv
// Sequencing controller for the REDUX-V stack. Accepts PUSH/POP/PEEK/CLEAR
// over valid/ready, owns the stack pointer and depth counter, drives an
// external single-port synchronous RAM and returns one response per request.
// Overflow/underflow are answered with an error response and leave pointer,
// counter and memory untouched.
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int unsigned     BITS    = BITS_DEF,
  parameter int unsigned     DEPTH   = 255,
  parameter logic [BITS-1:0] SP_BASE = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [1:0]      req_op,
  input  logic [BITS-1:0] req_data,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [BITS-1:0] rsp_data,
  output logic [BITS-1:0] mem_addr,
  output logic [BITS-1:0] mem_wdata,
  output logic            mem_we,
  output logic            mem_re,
  input  logic [BITS-1:0] mem_rdata,
  output logic [BITS-1:0] sp,
  output logic            full,
  output logic            empty
);

  // Counter needs one extra bit so DEPTH = 2^BITS is representable.
  localparam int unsigned CW      = BITS + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e          state_q;
  op_e             op_q;
  logic [BITS-1:0] sp_q;
  logic [CW-1:0]   cnt_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic            rsp_err_q;
  logic [BITS-1:0] rsp_data_q;
  logic [BITS-1:0] mem_addr_q;
  logic [BITS-1:0] mem_wdata_q;
  logic            mem_we_q;
  logic            mem_re_q;

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign sp        = sp_q;
  assign full      = (cnt_q == DEPTH_C);
  assign empty     = (cnt_q == '0);

  // Request FSM with registered strobes, pointer/counter and response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      sp_q        <= SP_BASE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
    end else begin
      // Strobes are single-cycle pulses unless re-armed below.
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q        <= op_e'(req_op);
            req_ready_q <= 1'b0;
            unique case (op_e'(req_op))
              OP_PUSH: begin
                if (full) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                end else begin
                  state_q     <= ST_PUSH_WR;
                  mem_we_q    <= 1'b1;
                  mem_addr_q  <= sp_q;
                  mem_wdata_q <= req_data;
                end
              end
              OP_POP, OP_PEEK: begin
                if (empty) begin
                  state_q     <= ST_RESP;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_data_q  <= '0;
                end else if (op_e'(req_op) == OP_POP) begin
                  state_q <= ST_POP_DEC;
                end else begin
                  // PEEK reads the top entry, one below the free slot.
                  state_q    <= ST_MEM_RD;
                  mem_re_q   <= 1'b1;
                  mem_addr_q <= sp_q - 1'b1;
                end
              end
              default: begin
                // CLEAR shares the pointer-update cycle with POP.
                state_q <= ST_POP_DEC;
              end
            endcase
          end
        end
        ST_PUSH_WR: begin
          sp_q        <= sp_q + 1'b1;
          cnt_q       <= cnt_q + 1'b1;
          rsp_data_q  <= sp_q + 1'b1;
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_POP_DEC: begin
          if (op_q == OP_CLEAR) begin
            sp_q        <= SP_BASE;
            cnt_q       <= '0;
            rsp_data_q  <= SP_BASE;
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
          end else begin
            // Read address is the decremented pointer.
            sp_q       <= sp_q - 1'b1;
            cnt_q      <= cnt_q - 1'b1;
            mem_re_q   <= 1'b1;
            mem_addr_q <= sp_q - 1'b1;
            state_q    <= ST_MEM_RD;
          end
        end
        ST_MEM_RD: begin
          state_q <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          rsp_data_q  <= mem_rdata;
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: two instances (DEPTH=4/SP_BASE=0x00 and
// DEPTH=255/SP_BASE=0xFF), each with its own stack_mem, driven by directed
// requests and checked against a queue-based stack model.
module tb_stack_ctrl;
  import stack_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] req_op;
  logic [7:0] req_data;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic       rsp_err   [2];
  logic       mem_we    [2];
  logic       mem_re    [2];
  logic       full      [2];
  logic       empty     [2];
  logic [7:0] rsp_data  [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];
  logic [7:0] sp        [2];

  stack_ctrl #(.BITS(8), .DEPTH(4), .SP_BASE(8'h00)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid[0]), .rsp_err(rsp_err[0]),
    .rsp_data(rsp_data[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_we(mem_we[0]), .mem_re(mem_re[0]), .mem_rdata(mem_rdata[0]), .sp(sp[0]),
    .full(full[0]), .empty(empty[0])
  );
  stack_mem #(.BITS(8)) u_mem_a (
    .clk(clk), .we_i(mem_we[0]), .re_i(mem_re[0]), .addr_i(mem_addr[0]),
    .wdata_i(mem_wdata[0]), .rdata_o(mem_rdata[0])
  );

  stack_ctrl #(.BITS(8), .DEPTH(255), .SP_BASE(8'hFF)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op), .req_data(req_data), .rsp_valid(rsp_valid[1]), .rsp_err(rsp_err[1]),
    .rsp_data(rsp_data[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_we(mem_we[1]), .mem_re(mem_re[1]), .mem_rdata(mem_rdata[1]), .sp(sp[1]),
    .full(full[1]), .empty(empty[1])
  );
  stack_mem #(.BITS(8)) u_mem_b (
    .clk(clk), .we_i(mem_we[1]), .re_i(mem_re[1]), .addr_i(mem_addr[1]),
    .wdata_i(mem_wdata[1]), .rdata_o(mem_rdata[1])
  );

  // ---------------- stack model ----------------
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  function automatic int m_depth(int s);
    return (s == 0) ? 4 : 255;
  endfunction
  function automatic logic [7:0] m_base(int s);
    return (s == 0) ? 8'h00 : 8'hFF;
  endfunction
  function automatic int m_size(int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction
  // Next free slot: base plus number of stored entries, modulo 256.
  function automatic logic [7:0] m_sp(int s);
    return m_base(s) + 8'(m_size(s));
  endfunction
  function automatic void m_push(int s, logic [7:0] d);
    if (s == 0) q0.push_back(d);
    else        q1.push_back(d);
  endfunction
  function automatic logic [7:0] m_pop(int s);
    if (s == 0) return q0.pop_back();
    return q1.pop_back();
  endfunction
  function automatic logic [7:0] m_top(int s);
    if (s == 0) return q0[$];
    return q1[$];
  endfunction
  function automatic void m_clear(int s);
    if (s == 0) q0.delete();
    else        q1.delete();
  endfunction

  // ---------------- checking ----------------
  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] last_rsp;
  logic [7:0] last_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_reset(input int s);
    chk("rst_req_ready", req_ready[s], 1);
    chk("rst_rsp_valid", rsp_valid[s], 0);
    chk("rst_rsp_err",   rsp_err[s],   0);
    chk("rst_rsp_data",  rsp_data[s],  0);
    chk("rst_mem_we",    mem_we[s],    0);
    chk("rst_mem_re",    mem_re[s],    0);
    chk("rst_mem_addr",  mem_addr[s],  0);
    chk("rst_mem_wdata", mem_wdata[s], 0);
    chk("rst_empty",     empty[s],     1);
    chk("rst_full",      full[s],      0);
    chk("rst_sp",        sp[s],        m_base(s));
  endtask

  // Issue one request to instance s and check every cycle up to its response.
  task automatic do_req(input int s, input logic [1:0] op, input logic [7:0] d);
    int         sz;
    int         lat;
    int         we_cyc;
    int         re_cyc;
    int         waitc;
    logic       err;
    logic [7:0] sp0;
    logic [7:0] exp_rsp;
    logic [7:0] exp_addr;
    sz = m_size(s);
    sp0 = m_sp(s);
    err = 1'b0; lat = 0; we_cyc = 0; re_cyc = 0; exp_rsp = '0; exp_addr = '0;
    case (op)
      2'd0: if (sz == m_depth(s)) err = 1'b1;
            else begin lat = 2; we_cyc = 1; exp_addr = sp0; m_push(s, d); exp_rsp = sp0 + 8'd1; end
      2'd1: if (sz == 0) err = 1'b1;
            else begin lat = 4; re_cyc = 2; exp_addr = sp0 - 8'd1; exp_rsp = m_pop(s); end
      2'd2: if (sz == 0) err = 1'b1;
            else begin lat = 3; re_cyc = 1; exp_addr = sp0 - 8'd1; exp_rsp = m_top(s); end
      default: begin lat = 2; m_clear(s); exp_rsp = m_base(s); end
    endcase
    if (err) begin lat = 1; exp_rsp = '0; end

    @(negedge clk);
    waitc = 0;
    while (!req_ready[s] && waitc < 20) begin @(negedge clk); waitc++; end
    chk("req_ready_idle", req_ready[s], 1);
    req_valid[s] = 1'b1; req_op = op; req_data = d;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("rsp_valid_cycle", rsp_valid[s], (k == lat));
      chk("req_ready_busy",  req_ready[s], 0);
      chk("mem_we_cycle",    mem_we[s],    (k == we_cyc));
      chk("mem_re_cycle",    mem_re[s],    (k == re_cyc));
      if (k == we_cyc) begin
        chk("wr_addr",  mem_addr[s],  exp_addr);
        chk("wr_wdata", mem_wdata[s], d);
        last_addr = mem_addr[s];
      end
      if (k == re_cyc) begin
        chk("rd_addr", mem_addr[s], exp_addr);
        last_addr = mem_addr[s];
      end
    end
    chk("rsp_err",  rsp_err[s],  err);
    chk("rsp_data", rsp_data[s], exp_rsp);
    chk("sp",       sp[s],       m_sp(s));
    chk("full",     full[s],     (m_size(s) == m_depth(s)));
    chk("empty",    empty[s],    (m_size(s) == 0));
    last_rsp = rsp_data[s];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    req_valid[0] = 1'b0; req_valid[1] = 1'b0;
    req_op = 2'd0; req_data = 8'h00;
    last_rsp = '0; last_addr = '0;
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;

    // Basic push / pop ordering
    do_req(0, 2'd0, 8'hA5);
    chk("pin_push_rsp",  last_rsp,  8'h01);
    chk("pin_push_addr", last_addr, 8'h00);
    do_req(0, 2'd1, 8'h00);
    chk("pin_pop_a5", last_rsp, 8'hA5);
    do_req(0, 2'd0, 8'h11);
    do_req(0, 2'd0, 8'h22);
    do_req(0, 2'd0, 8'h33);
    do_req(0, 2'd1, 8'h00); chk("pin_pop_33", last_rsp, 8'h33);
    do_req(0, 2'd1, 8'h00); chk("pin_pop_22", last_rsp, 8'h22);
    do_req(0, 2'd1, 8'h00); chk("pin_pop_11", last_rsp, 8'h11);
    chk("pin_sp_zero", sp[0],    8'h00);
    chk("pin_empty",   empty[0], 1);

    // PEEK leaves pointer and count alone
    do_req(0, 2'd0, 8'h7E);
    do_req(0, 2'd2, 8'h00);
    chk("pin_peek_data", last_rsp,  8'h7E);
    chk("pin_peek_addr", last_addr, 8'h00);
    chk("pin_peek_sp",   sp[0],     8'h01);
    do_req(0, 2'd1, 8'h00);

    // Fill to DEPTH=4, then overflow, clear, underflow
    for (int i = 0; i < 4; i++) do_req(0, 2'd0, 8'h10 + 8'(i));
    chk("pin_full", full[0], 1);
    do_req(0, 2'd0, 8'hEE);
    chk("pin_ovf_sp",  sp[0],    8'h04);
    chk("pin_ovf_rsp", last_rsp, 8'h00);
    do_req(0, 2'd3, 8'h00);
    chk("pin_clr_rsp", last_rsp, 8'h00);
    do_req(0, 2'd1, 8'h00);
    chk("pin_udf_sp", sp[0], 8'h00);
    do_req(0, 2'd2, 8'h00);

    // Wrap-around with SP_BASE = 0xFF
    do_req(1, 2'd0, 8'h5A);
    chk("pin_wrap_addr", last_addr, 8'hFF);
    chk("pin_wrap_sp",   sp[1],     8'h00);
    do_req(1, 2'd1, 8'h00);
    chk("pin_wrap_pop", last_rsp, 8'h5A);
    chk("pin_wrap_sp2", sp[1],    8'hFF);
    do_req(1, 2'd0, 8'hC3);
    do_req(1, 2'd0, 8'hD4);
    do_req(1, 2'd3, 8'h00);
    chk("pin_clr_ff",    last_rsp, 8'hFF);
    chk("pin_clr_empty", empty[1], 1);

    // Reset asserted during POP_DEC
    do_req(0, 2'd0, 8'h99);
    @(negedge clk);
    req_valid[0] = 1'b1; req_op = 2'd1; req_data = 8'h00;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    #2;
    chk("abort_busy", req_ready[0], 0);
    rst_n = 1'b0;
    #1;
    m_clear(0);
    m_clear(1);
    chk_reset(0);
    chk_reset(1);
    repeat (3) begin @(negedge clk); chk("abort_no_rsp_rst", rsp_valid[0], 0); end
    rst_n = 1'b1;
    repeat (4) begin @(negedge clk); chk("abort_no_rsp_idle", rsp_valid[0], 0); end
    do_req(0, 2'd0, 8'h42);
    chk("pin_abort_addr", last_addr, 8'h00);
    chk("pin_abort_rsp",  last_rsp,  8'h01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
